custom_bitrun_unit: RTL and testbench
=====================================

// Module: custom_bitrun_unit
// PURPOSE
//  Multi-cycle CV-X-IF coprocessor unit that measures a run of equal bits in rs0.
//  The run starts at bit index rs1 and moves up or down. It counts ones or zeros,
//  selected by funct3, and saturates at MAX_RUN.
//  Sits beside the core as an issue/commit/result coprocessor and handles one
//  instruction at a time.
// PARAMETERS
//  XLEN        32          operand/result width (power of 2, >=8)
//  MAX_RUN     XLEN        saturation limit of the count, 1..XLEN
//  X_ID_WIDTH  4           width of instruction id
//  OPCODE      7'b0001011  major opcode claimed by this unit (custom-0)
// PORTS
//  clk_i              in   1           clock
//  rst_ni             in   1           asynchronous reset, active-low
//  issue_valid_i      in   1           issue request valid
//  issue_ready_o      out  1           issue response valid / request consumed
//  issue_instr_i      in   32          instruction word
//  issue_id_i         in   X_ID_WIDTH  instruction id
//  issue_rs0_i        in   XLEN        source operand 0 (data word)
//  issue_rs1_i        in   XLEN        source operand 1 (start bit index)
//  issue_rs_valid_i   in   2           operand valid flags
//  issue_accept_o     out  1           instruction accepted
//  issue_writeback_o  out  1           instruction writes rd
//  commit_valid_i     in   1           commit strobe
//  commit_id_i        in   X_ID_WIDTH  committed/killed id
//  commit_kill_i      in   1           kill the instruction with commit_id_i
//  result_valid_o     out  1           result valid
//  result_ready_i     in   1           core accepts result
//  result_id_o        out  X_ID_WIDTH  id of result
//  result_data_o      out  XLEN        run length
//  result_rd_o        out  5           destination register
//  result_we_o        out  1           register write enable (rd != 0)
//  busy_o             out  1           high whenever state != IDLE
// BEHAVIOUR
//  - Reset: state IDLE.
//    - All outputs 0, except issue_ready_o, which follows the IDLE rule below.
//    - Internal count, position, id, rd and operand registers are cleared.
//    - Reset mid-operation abandons the instruction; no result is produced.
//  - funct3 = instr[14:12]:
//    - 000 ones, downward
//    - 001 zeros, downward
//    - 010 ones, upward
//    - 011 zeros, upward
//    - others unsupported
//  - Issue in IDLE:
//    - issue_ready_o = issue_valid_i & (unsupported | &issue_rs_valid_i).
//    - Supported means opcode == OPCODE and funct3 is in 000..011.
//    - Supported: accept = writeback = 1 combinationally in the handshake cycle.
//    - Unsupported: accept = writeback = 0 and the unit stays in IDLE.
//    - Outside IDLE: issue_ready_o = 0.
//  - Handshake on a supported instruction: latch the following, then go to COUNT.
//    - rs0
//    - pos = rs1[$clog2(XLEN)-1:0] (upper bits ignored)
//    - target bit, direction
//    - id, rd = instr[11:7]
//    - cnt = 0
//  - COUNT examines one bit per cycle:
//    - bit[pos] != target: go to RESP, cnt unchanged.
//    - Else cnt += 1. Go to RESP if the new cnt == MAX_RUN or pos is at the
//      boundary (0 downward, XLEN-1 upward). Otherwise step pos by 1.
//    - No wrap-around.
//  - COUNT cycle counts:
//    - N+1 cycles when stopped by a mismatch.
//    - N cycles when stopped by saturation or the boundary.
//    - N is the final count.
//  - RESP:
//    - result_valid_o = 1; data = zero-extended cnt; id, rd and we as latched.
//    - Outputs held stable until result_ready_i.
//    - The handshake cycle returns to IDLE.
//  - Kill: commit_valid_i & commit_kill_i & commit_id_i == latched id, in COUNT or RESP.
//    - Next state is IDLE.
//    - No result_valid_o after the kill cycle; a RESP being killed may still show
//      valid in that same cycle.
//    - If kill and result handshake coincide, the kill wins: the transfer is void
//      and the core discards it.
//  - Commit without kill, or with a non-matching id, is ignored.
// TESTING
//  1. rs0=0xF000_0000, rs1=31, f3=000 -> result 4 after 5 COUNT cycles; rd/id echo
//     the instruction; we=1.
//  2. rs0=0xFFFF_FFFF, rs1=31, f3=000 -> 32 via boundary stop (32 cycles); with
//     MAX_RUN=4 build -> 4 after 4 cycles.
//  3. rs0=0x0000_000F, rs1=4: f3=001 -> 1; f3=011 -> 28 (boundary); f3=010 -> 0.
//  4. rs0=0, rs1=5, f3=000 -> 0 after 1 COUNT cycle; rd=x0 -> result_we_o=0.
//  5. f3=111, or a foreign opcode -> issue_ready_o=1, accept=0, busy_o stays 0,
//     no result. rs_valid=2'b01 -> issue_ready_o=0 until both valid.
//  6. Kill in COUNT -> no result, issue_ready_o available next cycle.
//     result_ready_i low 3 cycles -> result held stable.
//     Async reset in COUNT -> all outputs 0.

Source files
------------

// File: rtl/custom_bitrun_unit.sv
// CV-X-IF coprocessor measuring a run of equal bits in rs0 starting at index rs1,
// counting ones or zeros up or down one bit per cycle with saturation at MAX_RUN.
module custom_bitrun_unit #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned MAX_RUN    = XLEN,
    parameter int unsigned X_ID_WIDTH = 4,
    parameter logic [6:0]  OPCODE     = 7'b0001011
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  issue_valid_i,
    output logic                  issue_ready_o,
    input  logic [31:0]           issue_instr_i,
    input  logic [X_ID_WIDTH-1:0] issue_id_i,
    input  logic [XLEN-1:0]       issue_rs0_i,
    input  logic [XLEN-1:0]       issue_rs1_i,
    input  logic [1:0]            issue_rs_valid_i,
    output logic                  issue_accept_o,
    output logic                  issue_writeback_o,
    input  logic                  commit_valid_i,
    input  logic [X_ID_WIDTH-1:0] commit_id_i,
    input  logic                  commit_kill_i,
    output logic                  result_valid_o,
    input  logic                  result_ready_i,
    output logic [X_ID_WIDTH-1:0] result_id_o,
    output logic [XLEN-1:0]       result_data_o,
    output logic [4:0]            result_rd_o,
    output logic                  result_we_o,
    output logic                  busy_o
);

    localparam int unsigned PW = $clog2(XLEN);
    localparam int unsigned CW = PW + 1;
    localparam logic [PW-1:0] POS_MAX = PW'(XLEN - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_RUN);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] COUNT = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [XLEN-1:0]       data_q, data_d;
    logic [PW-1:0]         pos_q, pos_d;
    logic                  target_q, target_d;
    logic                  dir_up_q, dir_up_d;
    logic [X_ID_WIDTH-1:0] id_q, id_d;
    logic [4:0]            rd_q, rd_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic [2:0]    funct3_s;
    logic          supported_s;
    logic          handshake_s;
    logic          kill_s;
    logic [CW-1:0] cnt_inc_s;
    logic          at_boundary_s;
    logic          unused_bits_s;

    // Issue-side decode and combinational handshake responses.
    always_comb begin
        funct3_s          = issue_instr_i[14:12];
        supported_s       = (issue_instr_i[6:0] == OPCODE) && (funct3_s[2] == 1'b0);
        issue_ready_o     = (state_q == IDLE) && issue_valid_i
                            && (!supported_s || (&issue_rs_valid_i));
        handshake_s       = issue_ready_o && supported_s;
        issue_accept_o    = handshake_s;
        issue_writeback_o = handshake_s;
        kill_s            = commit_valid_i && commit_kill_i && (commit_id_i == id_q)
                            && ((state_q == COUNT) || (state_q == RESP));
        unused_bits_s     = ^{issue_instr_i[31:15], issue_rs1_i[XLEN-1:PW]};
    end

    // Next-state and datapath update; a matching kill overrides everything.
    always_comb begin
        state_d       = state_q;
        data_d        = data_q;
        pos_d         = pos_q;
        target_d      = target_q;
        dir_up_d      = dir_up_q;
        id_d          = id_q;
        rd_d          = rd_q;
        cnt_d         = cnt_q;
        cnt_inc_s     = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        at_boundary_s = dir_up_q ? (pos_q == POS_MAX) : (pos_q == {PW{1'b0}});
        case (state_q)
            IDLE: begin
                if (handshake_s) begin
                    state_d  = COUNT;
                    data_d   = issue_rs0_i;
                    pos_d    = issue_rs1_i[PW-1:0];
                    target_d = ~funct3_s[0];
                    dir_up_d = funct3_s[1];
                    id_d     = issue_id_i;
                    rd_d     = issue_instr_i[11:7];
                    cnt_d    = {CW{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            COUNT: begin
                if (data_q[pos_q] != target_q) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_inc_s;
                    if ((cnt_inc_s == CNT_MAX) || at_boundary_s) begin
                        state_d = RESP;
                    end else if (dir_up_q) begin
                        pos_d = pos_q + {{(PW-1){1'b0}}, 1'b1};
                    end else begin
                        pos_d = pos_q - {{(PW-1){1'b0}}, 1'b1};
                    end
                end
            end
            RESP: begin
                if (result_ready_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (kill_s) begin
            state_d = IDLE;
        end else begin
            state_d = state_d;
        end
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            data_q   <= {XLEN{1'b0}};
            pos_q    <= {PW{1'b0}};
            target_q <= 1'b0;
            dir_up_q <= 1'b0;
            id_q     <= {X_ID_WIDTH{1'b0}};
            rd_q     <= 5'd0;
            cnt_q    <= {CW{1'b0}};
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            pos_q    <= pos_d;
            target_q <= target_d;
            dir_up_q <= dir_up_d;
            id_q     <= id_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
        end
    end

    // Result fields come straight from registers so they stay stable while RESP waits.
    always_comb begin
        result_valid_o = (state_q == RESP);
        result_id_o    = id_q;
        result_data_o  = {{(XLEN-CW){1'b0}}, cnt_q};
        result_rd_o    = rd_q;
        result_we_o    = (rd_q != 5'd0);
        busy_o         = (state_q != IDLE);
    end

endmodule

// File: tb/tb_custom_bitrun_unit.sv
// Directed bench for custom_bitrun_unit: vector table plus kill/hold/reset sequences,
// with a second MAX_RUN=4 instance for the saturation case.
module tb_custom_bitrun_unit;

    localparam logic [6:0] OP = 7'b0001011;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        issue_valid_i, issue_valid2;
    logic [31:0] issue_instr_i;
    logic [3:0]  issue_id_i;
    logic [31:0] issue_rs0_i, issue_rs1_i;
    logic [1:0]  issue_rs_valid_i;
    logic        commit_valid_i, commit_kill_i;
    logic [3:0]  commit_id_i;
    logic        result_ready_i, result_ready2;

    logic        issue_ready_o, issue_accept_o, issue_writeback_o;
    logic        result_valid_o, result_we_o, busy_o;
    logic [3:0]  result_id_o;
    logic [31:0] result_data_o;
    logic [4:0]  result_rd_o;

    logic        ready2, accept2, wb2, valid2, we2, busy2;
    logic [3:0]  id2;
    logic [31:0] data2;
    logic [4:0]  rd2;

    int nerr = 0;
    int nchk = 0;

    always #5 clk_i = ~clk_i;

    custom_bitrun_unit dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_instr_i(issue_instr_i), .issue_id_i(issue_id_i),
        .issue_rs0_i(issue_rs0_i), .issue_rs1_i(issue_rs1_i),
        .issue_rs_valid_i(issue_rs_valid_i), .issue_accept_o(issue_accept_o),
        .issue_writeback_o(issue_writeback_o),
        .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i),
        .commit_kill_i(commit_kill_i),
        .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
        .result_id_o(result_id_o), .result_data_o(result_data_o),
        .result_rd_o(result_rd_o), .result_we_o(result_we_o), .busy_o(busy_o)
    );

    custom_bitrun_unit #(.MAX_RUN(4)) dut_sat (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .issue_valid_i(issue_valid2), .issue_ready_o(ready2),
        .issue_instr_i(issue_instr_i), .issue_id_i(issue_id_i),
        .issue_rs0_i(issue_rs0_i), .issue_rs1_i(issue_rs1_i),
        .issue_rs_valid_i(issue_rs_valid_i), .issue_accept_o(accept2),
        .issue_writeback_o(wb2),
        .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i),
        .commit_kill_i(commit_kill_i),
        .result_valid_o(valid2), .result_ready_i(result_ready2),
        .result_id_o(id2), .result_data_o(data2),
        .result_rd_o(rd2), .result_we_o(we2), .busy_o(busy2)
    );

    typedef struct {
        logic [2:0]  f3;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [3:0]  id;
        logic [31:0] rs0;
        logic [31:0] rs1;
        logic        sup;
        logic [31:0] exp_data;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[10];

    function automatic logic [31:0] mk_instr(input logic [2:0] f3, input logic [4:0] rd,
                                             input logic [6:0] op);
        return {17'd0, f3, rd, op};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_issue(input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op,
                               input logic [3:0] id, input logic [31:0] rs0,
                               input logic [31:0] rs1);
        issue_instr_i    = mk_instr(f3, rd, op);
        issue_id_i       = id;
        issue_rs0_i      = rs0;
        issue_rs1_i      = rs1;
        issue_rs_valid_i = 2'b11;
        issue_valid_i    = 1'b1;
    endtask

    // Returns number of negedges observed in COUNT before RESP shows up.
    task automatic wait_result(output int cyc);
        cyc = 0;
        while (!result_valid_o && cyc < 200) begin
            cyc++;
            @(negedge clk_i);
        end
    endtask

    task automatic run_vec(input int k);
        int cyc;
        vec_t v;
        v = vecs[k];
        @(negedge clk_i);
        drive_issue(v.f3, v.rd, v.op, v.id, v.rs0, v.rs1);
        #1;
        chk($sformatf("v%0d ready", k), issue_ready_o, 1);
        chk($sformatf("v%0d accept", k), issue_accept_o, v.sup);
        chk($sformatf("v%0d writeback", k), issue_writeback_o, v.sup);
        @(negedge clk_i);
        issue_valid_i = 1'b0;
        if (!v.sup) begin
            chk($sformatf("v%0d busy", k), busy_o, 0);
            repeat (2) @(negedge clk_i);
            chk($sformatf("v%0d no result", k), result_valid_o, 0);
        end else begin
            wait_result(cyc);
            chk($sformatf("v%0d cycles", k), cyc, v.exp_cyc);
            chk($sformatf("v%0d data", k), result_data_o, v.exp_data);
            chk($sformatf("v%0d id", k), result_id_o, v.id);
            chk($sformatf("v%0d rd", k), result_rd_o, v.rd);
            chk($sformatf("v%0d we", k), result_we_o, (v.rd != 5'd0));
            result_ready_i = 1'b1;
            @(negedge clk_i);
            result_ready_i = 1'b0;
            chk($sformatf("v%0d valid after", k), result_valid_o, 0);
            chk($sformatf("v%0d busy after", k), busy_o, 0);
        end
    endtask

    initial begin
        int cyc;
        vecs[0] = '{3'b000, OP, 5'd5, 4'd3, 32'hF000_0000, 32'd31, 1'b1, 32'd4, 5};
        vecs[1] = '{3'b000, OP, 5'd7, 4'd1, 32'hFFFF_FFFF, 32'd31, 1'b1, 32'd32, 32};
        vecs[2] = '{3'b001, OP, 5'd1, 4'd2, 32'h0000_000F, 32'd4, 1'b1, 32'd1, 2};
        vecs[3] = '{3'b011, OP, 5'd2, 4'd4, 32'h0000_000F, 32'd4, 1'b1, 32'd28, 28};
        vecs[4] = '{3'b010, OP, 5'd3, 4'd5, 32'h0000_000F, 32'd4, 1'b1, 32'd0, 1};
        vecs[5] = '{3'b000, OP, 5'd0, 4'd6, 32'h0000_0000, 32'd5, 1'b1, 32'd0, 1};
        vecs[6] = '{3'b111, OP, 5'd4, 4'd7, 32'hFFFF_FFFF, 32'd3, 1'b0, 32'd0, 0};
        vecs[7] = '{3'b000, 7'b0101011, 5'd4, 4'd8, 32'hFFFF_FFFF, 32'd3, 1'b0, 32'd0, 0};
        vecs[8] = '{3'b010, OP, 5'd9, 4'd11, 32'h0000_00F0, 32'h24, 1'b1, 32'd4, 5};
        vecs[9] = '{3'b011, OP, 5'd31, 4'd12, 32'h8000_0000, 32'd0, 1'b1, 32'd31, 32};

        rst_ni = 1'b0;
        issue_valid_i = 1'b0; issue_valid2 = 1'b0;
        issue_instr_i = 32'd0; issue_id_i = 4'd0;
        issue_rs0_i = 32'd0; issue_rs1_i = 32'd0; issue_rs_valid_i = 2'b00;
        commit_valid_i = 1'b0; commit_kill_i = 1'b0; commit_id_i = 4'd0;
        result_ready_i = 1'b0; result_ready2 = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("reset busy", busy_o, 0);
        chk("reset valid", result_valid_o, 0);
        chk("reset data", result_data_o, 0);
        chk("reset ready", issue_ready_o, 0);
        chk("reset we", result_we_o, 0);
        rst_ni = 1'b1;

        for (int k = 0; k < 10; k++) run_vec(k);

        // Saturating instance: all-ones word stops at 4 after 4 cycles.
        @(negedge clk_i);
        drive_issue(3'b000, 5'd6, OP, 4'd13, 32'hFFFF_FFFF, 32'd31);
        issue_valid_i = 1'b0;
        issue_valid2  = 1'b1;
        #1;
        chk("sat accept", accept2, 1);
        @(negedge clk_i);
        issue_valid2 = 1'b0;
        cyc = 0;
        while (!valid2 && cyc < 200) begin
            cyc++;
            @(negedge clk_i);
        end
        chk("sat cycles", cyc, 4);
        chk("sat data", data2, 4);
        result_ready2 = 1'b1;
        @(negedge clk_i);
        result_ready2 = 1'b0;
        chk("sat busy after", busy2, 0);

        // Operand-valid gating, then hold result with result_ready low.
        drive_issue(3'b000, 5'd10, OP, 4'd14, 32'hF000_0000, 32'd31);
        issue_rs_valid_i = 2'b01;
        #1;
        chk("rsv ready low", issue_ready_o, 0);
        chk("rsv accept low", issue_accept_o, 0);
        @(negedge clk_i);
        chk("rsv still idle", busy_o, 0);
        issue_rs_valid_i = 2'b11;
        #1;
        chk("rsv ready high", issue_ready_o, 1);
        @(negedge clk_i);
        issue_valid_i = 1'b0;
        wait_result(cyc);
        chk("hold cycles", cyc, 5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk($sformatf("hold valid %0d", i), result_valid_o, 1);
            chk($sformatf("hold data %0d", i), result_data_o, 4);
            chk($sformatf("hold id %0d", i), result_id_o, 14);
        end
        result_ready_i = 1'b1;
        @(negedge clk_i);
        result_ready_i = 1'b0;
        chk("hold released", busy_o, 0);

        // Kill in COUNT: non-kill and wrong id ignored, matching kill aborts.
        drive_issue(3'b000, 5'd8, OP, 4'd9, 32'hFFFF_FFFF, 32'd31);
        @(negedge clk_i);
        issue_valid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        commit_valid_i = 1'b1; commit_kill_i = 1'b0; commit_id_i = 4'd9;
        @(negedge clk_i);
        chk("commit nokill busy", busy_o, 1);
        commit_kill_i = 1'b1; commit_id_i = 4'd8;
        @(negedge clk_i);
        chk("kill wrong id busy", busy_o, 1);
        commit_id_i = 4'd9;
        @(negedge clk_i);
        commit_valid_i = 1'b0; commit_kill_i = 1'b0;
        chk("kill busy", busy_o, 0);
        chk("kill valid", result_valid_o, 0);
        drive_issue(3'b000, 5'd8, OP, 4'd9, 32'h0, 32'd0);
        #1;
        chk("kill ready next", issue_ready_o, 1);
        issue_valid_i = 1'b0;
        repeat (40) begin
            @(negedge clk_i);
            if (result_valid_o) chk("kill no result", result_valid_o, 0);
        end

        // Kill coinciding with result handshake.
        drive_issue(3'b000, 5'd3, OP, 4'd10, 32'h0, 32'd5);
        @(negedge clk_i);
        issue_valid_i = 1'b0;
        wait_result(cyc);
        chk("krsp valid", result_valid_o, 1);
        commit_valid_i = 1'b1; commit_kill_i = 1'b1; commit_id_i = 4'd10;
        result_ready_i = 1'b1;
        @(negedge clk_i);
        commit_valid_i = 1'b0; commit_kill_i = 1'b0; result_ready_i = 1'b0;
        chk("krsp valid after", result_valid_o, 0);
        chk("krsp busy after", busy_o, 0);

        // Asynchronous reset in COUNT.
        drive_issue(3'b010, 5'd12, OP, 4'd15, 32'hFFFF_FFFF, 32'd0);
        @(negedge clk_i);
        issue_valid_i = 1'b0;
        @(negedge clk_i);
        chk("pre-reset busy", busy_o, 1);
        rst_ni = 1'b0;
        #1;
        chk("areset busy", busy_o, 0);
        chk("areset valid", result_valid_o, 0);
        chk("areset data", result_data_o, 0);
        chk("areset id", result_id_o, 0);
        chk("areset rd", result_rd_o, 0);
        chk("areset we", result_we_o, 0);
        chk("areset ready", issue_ready_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (3) @(negedge clk_i);
        chk("post-reset no result", result_valid_o, 0);
        run_vec(0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
